// File: rtl/prm_oblgc_seq.sv
// Obstacle-voxel to edge-check sequencer: collects the voxel set for a scene, presents it to the edge checkers,
// captures the blocked-edge mask, counts the blocked edges one lane per cycle, and holds the result until it is consumed.
//
// state     | meaning
// COLLECT   | accepting voxel beats into the occupancy register
// SETTLE    | query vector held steady while the checkers resolve
// COUNT     | popcount of the captured mask, one lane per cycle
// DONE      | result presented until the res handshake
module prm_oblgc_seq #(
    parameter int NUM_EDGE   = 32,
    parameter int SETTLE_CYC = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                clr,
    input  logic                vox_valid,
    output logic                vox_ready,
    input  logic [3:0]          vox_id,
    input  logic                vox_last,
    output logic [14:0]         chk_vec,
    input  logic [NUM_EDGE-1:0] chk_mask,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [NUM_EDGE-1:0] res_mask,
    output logic [6:0]          res_count,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_SETTLE  = 2'd1,
        S_COUNT   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [6:0] SETTLE_LOAD = 7'(SETTLE_CYC - 1);
    localparam logic [6:0] COUNT_LOAD  = 7'(NUM_EDGE - 1);

    state_t              state_q, state_d;
    logic [6:0]          tmr_q;
    logic [14:0]         occ_q;
    logic [NUM_EDGE-1:0] sh_q;
    logic                accept;
    logic                res_hs;
    logic                tmr_tc;

    assign accept    = vox_valid & vox_ready & ~clr;
    assign res_hs    = res_valid & res_ready & (state_q == S_DONE) & ~clr;
    assign tmr_tc    = (tmr_q == 7'd0);
    assign chk_vec   = occ_q;
    assign busy      = (state_q != S_COLLECT);

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_COLLECT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (accept && vox_last) state_d = S_SETTLE;
            S_SETTLE:  if (tmr_tc)             state_d = S_COUNT;
            S_COUNT:   if (tmr_tc)             state_d = S_DONE;
            S_DONE:    if (res_hs)             state_d = S_COLLECT;
            default:                           state_d = S_COLLECT;
        endcase
        if (clr) state_d = S_COLLECT;
    end

    // res_valid is registered off DONE, so it rises one cycle after DONE is entered.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            vox_ready <= 1'b1;
            res_valid <= 1'b0;
            occ_q     <= '0;
            tmr_q     <= '0;
            sh_q      <= '0;
            res_mask  <= '0;
            res_count <= '0;
        end else begin
            vox_ready <= (state_d == S_COLLECT);
            res_valid <= (state_q == S_DONE) & ~res_hs;
            case (state_q)
                S_COLLECT: begin
                    if (accept && vox_id != 4'd15) occ_q[vox_id] <= 1'b1;
                    if (accept && vox_last)        tmr_q <= SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (tmr_tc) begin
                        res_mask  <= chk_mask;
                        sh_q      <= chk_mask;
                        res_count <= '0;
                        tmr_q     <= COUNT_LOAD;
                    end else begin
                        tmr_q <= tmr_q - 7'd1;
                    end
                end
                S_COUNT: begin
                    res_count <= res_count + {6'd0, sh_q[0]};
                    sh_q      <= sh_q >> 1;
                    if (!tmr_tc) tmr_q <= tmr_q - 7'd1;
                end
                S_DONE: begin
                    if (res_hs) occ_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prm_oblgc_seq.sv
// Bench for prm_oblgc_seq: table of scenes plus random scenes against a set-based model, and hand-written
// abort/reset sequences.
module tb_prm_oblgc_seq;

    localparam int NE = 32;
    localparam int LAT = 1 + NE + 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          clr;
    logic          vox_valid;
    logic          vox_ready;
    logic [3:0]    vox_id;
    logic          vox_last;
    logic [14:0]   chk_vec;
    logic [NE-1:0] chk_mask;
    logic          res_valid;
    logic          res_ready;
    logic [NE-1:0] res_mask;
    logic [6:0]    res_count;
    logic          busy;

    int checks = 0;
    int errors = 0;

    assign chk_mask = {17'd0, chk_vec};

    prm_oblgc_seq #(.NUM_EDGE(NE), .SETTLE_CYC(1)) dut (
        .CLK(CLK), .RST(RST), .clr(clr),
        .vox_valid(vox_valid), .vox_ready(vox_ready), .vox_id(vox_id), .vox_last(vox_last),
        .chk_vec(chk_vec), .chk_mask(chk_mask),
        .res_valid(res_valid), .res_ready(res_ready), .res_mask(res_mask), .res_count(res_count),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] ids;
        int          n;
        logic [14:0] exp_vec;
        int          exp_cnt;
        int          stall;
    } scene_t;

    scene_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Sends beats (nibbles of ids, LSB first), returns once the vox_last beat edge has passed.
    task automatic send_beats(input logic [63:0] ids, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                @(negedge CLK);
                vox_valid = 1'b0;
                @(posedge CLK);
            end
            @(negedge CLK);
            vox_valid = 1'b1;
            vox_id    = ids[4*i +: 4];
            vox_last  = (i == n - 1);
            @(posedge CLK);
        end
    endtask

    task automatic run_scene(input logic [63:0] ids, input int n, input logic [14:0] exp_vec,
                             input int exp_cnt, input int stall, input bit gaps);
        int lat;
        int unstable;
        send_beats(ids, n, gaps);
        @(negedge CLK);
        vox_valid = 1'b0;
        vox_last  = 1'b0;
        check("settle_chk_vec", 64'(chk_vec), 64'(exp_vec));
        check("settle_busy", 64'(busy), 64'd1);
        lat = 0;
        unstable = 0;
        while (!res_valid && lat < 200) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (chk_vec !== exp_vec) unstable++;
        end
        check("latency", 64'(lat), 64'(LAT));
        check("chk_vec_stable", 64'(unstable), 64'd0);
        check("res_mask", 64'(res_mask), 64'({17'd0, exp_vec}));
        check("res_count", 64'(res_count), 64'(exp_cnt));
        vox_valid = 1'b1;
        vox_id    = 4'd9;
        unstable  = 0;
        for (int k = 0; k < stall; k++) begin
            @(negedge CLK);
            if (!res_valid || vox_ready || res_mask !== {17'd0, exp_vec} ||
                res_count !== 7'(exp_cnt) || chk_vec !== exp_vec) unstable++;
        end
        if (stall > 0) check("done_hold", 64'(unstable), 64'd0);
        res_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        res_ready = 1'b0;
        vox_valid = 1'b0;
        check("post_hs", 64'({res_valid, vox_ready, busy, chk_vec}), 64'({1'b0, 1'b1, 1'b0, 15'd0}));
        check("post_hs_mask_held", 64'(res_mask), 64'({17'd0, exp_vec}));
    endtask

    initial begin
        logic [63:0] rids;
        logic [14:0] mvec;
        int          n;
        int          seen;

        RST = 1'b1; clr = 1'b0; vox_valid = 1'b0; vox_id = 4'd0; vox_last = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_state", 64'({vox_ready, busy, res_valid, chk_vec}), 64'({1'b1, 1'b0, 1'b0, 15'd0}));
        check("reset_res", 64'({res_mask, res_count}), 64'd0);
        RST = 1'b0;

        tbl[0] = '{ids: 64'hE73,                 n: 3,  exp_vec: 15'h4088, exp_cnt: 3,  stall: 0};
        tbl[1] = '{ids: 64'hF,                   n: 1,  exp_vec: 15'h0000, exp_cnt: 0,  stall: 2};
        tbl[2] = '{ids: 64'hEDCB_A987_6554_3210, n: 16, exp_vec: 15'h7FFF, exp_cnt: 15, stall: 10};
        tbl[3] = '{ids: 64'h0,                   n: 1,  exp_vec: 15'h0001, exp_cnt: 1,  stall: 1};
        tbl[4] = '{ids: 64'h19F9F,               n: 5,  exp_vec: 15'h0202, exp_cnt: 2,  stall: 3};
        for (int t = 0; t < 5; t++)
            run_scene(tbl[t].ids, tbl[t].n, tbl[t].exp_vec, tbl[t].exp_cnt, tbl[t].stall, 1'b0);

        for (int r = 0; r < 20; r++) begin
            n    = $urandom_range(1, 16);
            rids = {$urandom, $urandom};
            mvec = '0;
            for (int i = 0; i < n; i++)
                if (rids[4*i +: 4] != 4'd15) mvec = mvec | (15'd1 << rids[4*i +: 4]);
            run_scene(rids, n, mvec, $countones(mvec), $urandom_range(0, 3), 1'b1);
        end

        // Abort in the 5th COUNT cycle with a coincident last beat.
        send_beats(64'hE73, 3, 1'b0);
        @(negedge CLK);
        vox_valid = 1'b0;
        vox_last  = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        clr = 1'b1; vox_valid = 1'b1; vox_id = 4'd6; vox_last = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        clr = 1'b0; vox_valid = 1'b0; vox_last = 1'b0;
        check("abort_state", 64'({busy, vox_ready, res_valid, chk_vec}), 64'({1'b0, 1'b1, 1'b0, 15'd0}));
        check("abort_res", 64'({res_mask, res_count}), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (res_valid || busy) seen++;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        run_scene(64'h2, 1, 15'h0004, 1, 0, 1'b0);

        // Reset during SETTLE.
        send_beats(64'h951, 3, 1'b0);
        @(negedge CLK);
        vox_valid = 1'b0;
        vox_last  = 1'b0;
        check("pre_rst_busy", 64'(busy), 64'd1);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("rst_mid_state", 64'({vox_ready, busy, res_valid, chk_vec}), 64'({1'b1, 1'b0, 1'b0, 15'd0}));
        check("rst_mid_res", 64'({res_mask, res_count}), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (res_valid) seen++;
        end
        check("rst_no_result", 64'(seen), 64'd0);
        run_scene(64'hA, 1, 15'h0400, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
